// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction field layout, opcode map and the fetch
// controller state encoding used by the RTL and the bench.
package isa_pkg;

  localparam int PC_W      = 6;
  localparam int INSTR_W   = 20;
  localparam int PROG_LAST = 45;

  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 16;
  localparam int TGT_MSB = 15;
  localparam int TGT_LSB = 10;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_LDI  = 4'h1;
  localparam logic [3:0] OPC_LD   = 4'h2;
  localparam logic [3:0] OPC_ST   = 4'h3;
  localparam logic [3:0] OPC_ADD  = 4'h4;
  localparam logic [3:0] OPC_SUB  = 4'h5;
  localparam logic [3:0] OPC_AND  = 4'h6;
  localparam logic [3:0] OPC_OR   = 4'h7;
  localparam logic [3:0] OPC_XOR  = 4'h8;
  localparam logic [3:0] OPC_SHL  = 4'h9;
  localparam logic [3:0] OPC_JMPZ = 4'hB;
  localparam logic [3:0] OPC_JMP  = 4'hC;
  localparam logic [3:0] OPC_END  = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_EXEC,
    ST_HALT
  } state_t;

  function automatic logic is_jump(input logic [3:0] opc);
    return (opc == OPC_JMP) || (opc == OPC_JMPZ);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection (increment, taken jump) and overrun detection
// against the last legal program address.
module pc_next_calc #(
  parameter int PC_W      = isa_pkg::PC_W,
  parameter int PROG_LAST = isa_pkg::PROG_LAST
) (
  input  logic [PC_W-1:0] pc,
  input  logic [3:0]      opc,
  input  logic [PC_W-1:0] target,
  input  logic            z_flag,
  input  logic            step_only,
  output logic [PC_W-1:0] next_pc,
  output logic            over
);
  import isa_pkg::*;

  localparam logic [PC_W:0] LAST = (PC_W+1)'(PROG_LAST);

  // One extra bit so an increment from the top address is seen as an overrun
  // rather than wrapping to 0.
  logic [PC_W:0] cand;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cand = {1'b0, pc} + (PC_W+1)'(1);
    if (!step_only) begin
      if ((opc == OPC_JMP) || ((opc == OPC_JMPZ) && z_flag))
        cand = {1'b0, target};
    end
    over    = (cand > LAST);
    next_pc = cand[PC_W-1:0];
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter / fetch FSM in front of a synchronous-read IRAM; resolves
// JMP/JMPZ/END locally and hands other instructions to the datapath.
module pc_fetch_ctrl #(
  parameter int PC_W      = isa_pkg::PC_W,
  parameter int INSTR_W   = isa_pkg::INSTR_W,
  parameter int PROG_LAST = isa_pkg::PROG_LAST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               z_flag,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               exec_done,
  output logic               busy,
  output logic               halted,
  output logic               overrun
);
  import isa_pkg::*;

  state_t          state;
  logic [3:0]      opc;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] next_pc;
  logic            over;

  assign opc    = instr_in[OPC_MSB:OPC_LSB];
  assign target = instr_in[TGT_MSB:TGT_LSB];

  // In EXEC the only legal move is +1; in LATCH the opcode chooses.
  pc_next_calc #(
    .PC_W      (PC_W),
    .PROG_LAST (PROG_LAST)
  ) u_next (
    .pc        (pc),
    .opc       (opc),
    .target    (target),
    .z_flag    (z_flag),
    .step_only (state == ST_EXEC),
    .next_pc   (next_pc),
    .over      (over)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      // NOTE: non-blocking default here is overridden by a later <= in the same
      // cycle, which is what makes ir_valid a single-cycle pulse.
      ir_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            pc      <= '0;
            overrun <= 1'b0;
            halted  <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          if (opc == OPC_END) begin
            busy   <= 1'b0;
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (is_jump(opc)) begin
            if (over) begin
              overrun <= 1'b1;
              busy    <= 1'b0;
              halted  <= 1'b1;
              state   <= ST_HALT;
            end else begin
              pc    <= next_pc;
              state <= ST_FETCH;
            end
          end else begin
            ir       <= instr_in;
            ir_valid <= 1'b1;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            if (over) begin
              overrun <= 1'b1;
              busy    <= 1'b0;
              halted  <= 1'b1;
              state   <= ST_HALT;
            end else begin
              pc    <= next_pc;
              state <= ST_FETCH;
            end
          end
        end
        default: begin
          busy   <= 1'b0;
          halted <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: small IRAM model, auto exec_done responder,
// table of tiny programs checked through a scoreboard, plus corner sequences.
module tb_pc_fetch_ctrl;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  pc;
  logic [19:0] instr_in = '0;
  logic        z_flag = 1'b0;
  logic [19:0] ir;
  logic        ir_valid;
  logic        exec_done;
  logic        busy, halted, overrun;

  logic        auto_en = 1'b0;
  logic        auto_done = 1'b0;
  logic        man_done = 1'b0;
  int          dly = 0;
  int          pulse_total = 0;
  logic        both_seen = 1'b0;
  logic [19:0] prog [64];

  int n_pass = 0;
  int n_total = 0;

  assign exec_done = auto_done | man_done;

  pc_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc        (pc),
    .instr_in  (instr_in),
    .z_flag    (z_flag),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .exec_done (exec_done),
    .busy      (busy),
    .halted    (halted),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read IRAM
  always @(posedge clk) instr_in <= prog[pc];

  // Monitor: ir_valid pulses and the busy/halted exclusivity
  initial forever begin
    @(negedge clk);
    if (ir_valid) pulse_total++;
    if (busy && halted) both_seen = 1'b1;
  end

  // Datapath stand-in: answers each ir_valid after dly cycles (0 = same cycle)
  initial forever begin
    @(negedge clk);
    if (auto_en && ir_valid) begin
      repeat (dly) @(negedge clk);
      auto_done = 1'b1;
      @(negedge clk);
      auto_done = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  typedef struct {
    logic [5:0]  a0, a1, a2;
    logic [19:0] d0, d1, d2;
    logic        z;
    int          dly;
    logic [5:0]  pc;
    logic        ovf;
    logic [19:0] ir;
    int          pulses;
  } vec_t;

  typedef struct {
    logic [5:0]  pc;
    logic        ovf;
    logic [19:0] ir;
    int          pulses;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[12];

  function automatic vec_t mk(input logic [5:0] a0, input logic [19:0] d0,
                              input logic [5:0] a1, input logic [19:0] d1,
                              input logic [5:0] a2, input logic [19:0] d2,
                              input logic z, input int dl, input logic [5:0] epc,
                              input logic eov, input logic [19:0] eir, input int ep);
    vec_t v;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.a2 = a2; v.d2 = d2;
    v.z = z; v.dly = dl; v.pc = epc; v.ovf = eov; v.ir = eir; v.pulses = ep;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = '0;
  endtask

  task automatic wait_halt(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (halted) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    int   base;
    clear_prog();
    prog[v.a0] = v.d0;
    prog[v.a1] = v.d1;
    prog[v.a2] = v.d2;
    z_flag  = v.z;
    dly     = v.dly;
    auto_en = 1'b1;
    do_reset();
    e.pc = v.pc; e.ovf = v.ovf; e.ir = v.ir; e.pulses = v.pulses;
    exp_q.push_back(e);
    base  = pulse_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_halt($sformatf("v%0d_halt", idx));
    got.pc = pc; got.ovf = overrun; got.ir = ir; got.pulses = pulse_total - base;
    e = exp_q.pop_front();
    check($sformatf("v%0d_pc", idx), 32'(got.pc), 32'(e.pc));
    check($sformatf("v%0d_overrun", idx), 32'(got.ovf), 32'(e.ovf));
    check($sformatf("v%0d_ir", idx), 32'(got.ir), 32'(e.ir));
    check($sformatf("v%0d_pulses", idx), 32'(got.pulses), 32'(e.pulses));
  endtask

  initial begin
    //               a0  d0         a1  d1         a2  d2         z  dly pc  ov ir         pulses
    vecs[0]  = mk(0, 20'h31000, 1,  20'hE0000, 63, 20'h0,     0, 2,  1,  0, 20'h31000, 1);
    vecs[1]  = mk(0, 20'hC3000, 12, 20'hE0000, 63, 20'h0,     0, 1,  12, 0, 20'h0,     0);
    vecs[2]  = mk(0, 20'hB8400, 33, 20'hE0000, 63, 20'h0,     1, 1,  33, 0, 20'h0,     0);
    vecs[3]  = mk(0, 20'hC5000, 20, 20'hB8400, 21, 20'hE0000, 0, 1,  21, 0, 20'h0,     0);
    vecs[4]  = mk(0, 20'hC8000, 32, 20'hE0000, 63, 20'h0,     0, 1,  32, 0, 20'h0,     0);
    vecs[5]  = mk(0, 20'hCB400, 45, 20'h31000, 63, 20'h0,     0, 1,  45, 1, 20'h31000, 1);
    vecs[6]  = mk(0, 20'hCC800, 63, 20'h0,     63, 20'h0,     0, 1,  0,  1, 20'h0,     0);
    vecs[7]  = mk(0, 20'hBC800, 1,  20'hE0000, 63, 20'h0,     0, 1,  1,  0, 20'h0,     0);
    vecs[8]  = mk(0, 20'hBC800, 63, 20'h0,     63, 20'h0,     1, 1,  0,  1, 20'h0,     0);
    vecs[9]  = mk(0, 20'hCB400, 45, 20'hE0000, 63, 20'h0,     0, 1,  45, 0, 20'h0,     0);
    vecs[10] = mk(0, 20'h10005, 1,  20'h51234, 2,  20'hE0000, 0, 0,  2,  0, 20'h51234, 2);
    vecs[11] = mk(0, 20'hA0001, 1,  20'hD0000, 2,  20'hE0000, 0, 0,  2,  0, 20'hD0000, 2);

    // Reset values, then first instruction latency and start-while-busy
    clear_prog();
    prog[0] = 20'h31000;
    auto_en = 1'b0;
    do_reset();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fetch_pc", 32'(pc), 32'd0);
    check("fetch_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("latch_ir_valid", 32'(ir_valid), 32'd0);
    @(negedge clk);
    check("exec_ir", 32'(ir), 32'h31000);
    check("exec_ir_valid", 32'(ir_valid), 32'd1);
    @(negedge clk);
    check("pulse_one_cycle", 32'(ir_valid), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_pc", 32'(pc), 32'd0);
    check("busy_start_busy", 32'(busy), 32'd1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    check("exec_done_pc", 32'(pc), 32'd1);
    check("exec_done_busy", 32'(busy), 32'd1);

    // Reset in the middle of EXEC with exec_done asserted at pc=7
    clear_prog();
    prog[0] = 20'hC1C00;
    prog[7] = 20'h31000;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clk);
        if (ir_valid) seen = 1'b1;
      end
      check("midexec_reached", 32'(seen), 32'd1);
    end
    check("midexec_pc", 32'(pc), 32'd7);
    rst = 1'b1;
    man_done = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_ir", 32'(ir), 32'd0);
    check("midrst_ir_valid", 32'(ir_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    man_done = 1'b0;
    check("idle_done_pc", 32'(pc), 32'd0);
    check("idle_done_busy", 32'(busy), 32'd0);

    // Program table through the scoreboard
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Restart from an overrun halt clears overrun and halted next cycle
    run_vec(12, vecs[6]);
    check("halt_busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_halted", 32'(halted), 32'd0);
    check("restart_overrun", 32'(overrun), 32'd0);
    check("restart_pc", 32'(pc), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    wait_halt("restart_halt");

    check("busy_halted_exclusive", 32'(both_seen), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
